// File: rtl/rv_muldiv_pkg.sv
// Shared types for the iterative RV32M/RV64M multiply/divide unit.
//   muldiv_op_e    : func3 encodings of the eight M-extension operations
//   muldiv_state_e : control FSM states
//   muldiv_ctrl_t  : decoded operation controls produced by muldiv_op_dec
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

    // is_rem_or_high selects the remainder for divides and the upper product
    // half for multiplies.
    typedef struct packed {
        logic is_div;
        logic is_rem_or_high;
        logic rs1_signed;
        logic rs2_signed;
    } muldiv_ctrl_t;

endpackage

// File: rtl/muldiv_op_dec.sv
// Combinational func3 decoder for the multiply/divide unit.
//   func3 : M-extension func3 field
//   ctrl  : decoded operation class, result selection and operand signedness
module muldiv_op_dec
    import rv_muldiv_pkg::*;
(
    input  logic [2:0]   func3,
    output muldiv_ctrl_t ctrl
);

    muldiv_op_e op;
    assign op = muldiv_op_e'(func3);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        ctrl = '0;
        case (op)
            // The low product half is identical for any signedness, so MUL
            // runs on raw bit patterns.
            F3_MUL:    ctrl = '{is_div: 1'b0, is_rem_or_high: 1'b0, rs1_signed: 1'b0, rs2_signed: 1'b0};
            F3_MULH:   ctrl = '{is_div: 1'b0, is_rem_or_high: 1'b1, rs1_signed: 1'b1, rs2_signed: 1'b1};
            F3_MULHSU: ctrl = '{is_div: 1'b0, is_rem_or_high: 1'b1, rs1_signed: 1'b1, rs2_signed: 1'b0};
            F3_MULHU:  ctrl = '{is_div: 1'b0, is_rem_or_high: 1'b1, rs1_signed: 1'b0, rs2_signed: 1'b0};
            F3_DIV:    ctrl = '{is_div: 1'b1, is_rem_or_high: 1'b0, rs1_signed: 1'b1, rs2_signed: 1'b1};
            F3_DIVU:   ctrl = '{is_div: 1'b1, is_rem_or_high: 1'b0, rs1_signed: 1'b0, rs2_signed: 1'b0};
            F3_REM:    ctrl = '{is_div: 1'b1, is_rem_or_high: 1'b1, rs1_signed: 1'b1, rs2_signed: 1'b1};
            F3_REMU:   ctrl = '{is_div: 1'b1, is_rem_or_high: 1'b1, rs1_signed: 1'b0, rs2_signed: 1'b0};
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign-corrected at the end.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : abandon any in-flight operation
//   in_valid / in_ready : operation request handshake (func3, rs1, rs2)
//   out_valid/out_ready : result handshake (result)
//   busy                : operation in CALC or waiting in DONE
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    muldiv_ctrl_t    ctrl_in;
    logic            accept, special;
    logic            rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0] rs1_mag, rs2_mag, special_val;

    // hi/lo: running product {hi,lo} with the multiplier shifting out of lo,
    // or remainder (hi) and dividend-shifting-into-quotient (lo) for divides.
    logic            is_div_q, sel_q, neg_q, rem_neg_q;
    logic [XLEN-1:0] hi_q, lo_q, opb_q, result_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_step, lo_step, quo_c, rem_c, corrected;
    logic [2*XLEN-1:0] prod_c;

    muldiv_op_dec u_dec (
        .func3 (func3),
        .ctrl  (ctrl_in)
    );

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign result    = result_q;

    // Operand conditioning and special-case detection at the accept edge.
    always_comb begin
        rs1_neg  = ctrl_in.rs1_signed && rs1[XLEN-1];
        rs2_neg  = ctrl_in.rs2_signed && rs2[XLEN-1];
        rs1_mag  = rs1_neg ? -rs1 : rs1;
        rs2_mag  = rs2_neg ? -rs2 : rs2;
        div_zero = ctrl_in.is_div && (rs2 == '0);
        div_ovf  = ctrl_in.is_div && ctrl_in.rs1_signed && (rs1 == MIN_NEG) && (rs2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_val = ctrl_in.is_rem_or_high ? rs1 : '1;
        else
            special_val = ctrl_in.is_rem_or_high ? '0 : rs1;
    end

    // One iteration step, plus sign correction of the stepped values (used on
    // the final step).
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            // Remainder stays below the divisor, so a set top bit of the
            // difference can only mean a borrow.
            hi_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_c = neg_q ? -{hi_step, lo_step} : {hi_step, lo_step};
        quo_c  = neg_q ? -lo_step : lo_step;
        rem_c  = rem_neg_q ? -hi_step : hi_step;
        if (is_div_q)
            corrected = sel_q ? rem_c : quo_c;
        else
            corrected = sel_q ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == LAST_STEP) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_div_q  <= 1'b0;
            sel_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (flush) begin
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    is_div_q  <= ctrl_in.is_div;
                    sel_q     <= ctrl_in.is_rem_or_high;
                    neg_q     <= rs1_neg ^ rs2_neg;
                    rem_neg_q <= rs1_neg;
                    hi_q      <= '0;
                    lo_q      <= ctrl_in.is_div ? rs1_mag : rs2_mag;
                    opb_q     <= ctrl_in.is_div ? rs2_mag : rs1_mag;
                    cnt_q     <= '0;
                    if (special)
                        result_q <= special_val;
                end
                CALC: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP)
                        result_q <= corrected;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=32): directed operations with
// hand-computed results, plus an arithmetic reference model checked whenever
// out_valid is high.
module tb_rv_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1, rs2, result;
    logic [XLEN-1:0] exp_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func3     (func3),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics straight from the M-extension definition.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Whenever a result is presented it must match the model for the
    // operation most recently issued.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1)
            check("model_result", {32'b0, result}, {32'b0, exp_result});
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    // Issue one operation and accept its result.  lat is the number of clock
    // edges after the accept edge up to and including the first edge that
    // samples out_valid high.  hold is how many cycles out_ready stays low.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int lat, input int hold);
        int n = 0;
        wait_ready(name);
        func3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
        exp_result = model(f3, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; func3 = 3'($urandom_range(7, 0));
        while (out_valid !== 1'b1 && n < 200) begin
            check({name, "_busy_calc"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n + 1), 64'(lat));
        check({name, "_result"}, {32'b0, result}, {32'b0, lit});
        check({name, "_busy_done"}, 64'(busy), 64'd1);
        check({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_result"}, {32'b0, result}, {32'b0, lit});
            check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_drained"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    // Start a normal MUL and leave it 10 cycles into CALC.
    task automatic start_mul(input string name);
        wait_ready(name);
        func3 = 3'b000; rs1 = 32'd99; rs2 = 32'd77; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check({name, "_midcalc_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic expect_quiet(input string name);
        int rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) rises++;
        end
        check({name, "_no_out_valid"}, 64'(rises), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        func3 = '0; rs1 = '0; rs2 = '0; exp_result = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", {32'b0, result}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Multiplies: full latency, including by zero.
        run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("mul_zero", 3'b000, 32'd0,       32'd5,         32'd0,         33, 0);

        // Divides.
        run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0);
        run_op("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1,         33, 0);

        // Special cases resolve in one cycle.
        run_op("div_by0",  3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("remu_by0", 3'b111, 32'd5,         32'd0,         32'd5,         1, 0);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

        // Back-pressure in DONE, then a back-to-back operation.
        run_op("mul_hold", 3'b000, 32'h0000_1234, 32'h10, 32'h0001_2340, 33, 5);
        run_op("remu_b2b", 3'b111, 32'd100,       32'd7,  32'd2,         33, 0);

        // flush together with in_valid in IDLE must not accept.
        func3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);
        check("flush_idle_in_ready", 64'(in_ready), 64'd1);

        // Flush mid-CALC.
        start_mul("flush");
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        expect_quiet("flush");
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0);

        // Reset mid-CALC.
        start_mul("reset");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_result", {32'b0, result}, 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("reset_recover_in_ready", 64'(in_ready), 64'd1);
        expect_quiet("reset");
        run_op("mul_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
